raycast_column_scheduler: RTL and testbench



---
 rtl/raycast_column_scheduler.sv | 117 +++++++++++
 tb/tb_raycast_column_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/raycast_column_scheduler.sv
// raycast_column_scheduler: per-column ray issue, engine result merge and column hand-off; RAYSCHED_TIMEOUT_EN adds a WAIT watchdog.
module raycast_column_scheduler #(
  parameter int NUM_COLS       = 320,
  parameter int HALF_FOV_Q4    = 480,
  parameter int ANGLE_STEP_Q4  = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic [11:0] player_angle,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [11:0] ray_alpha,
  output logic [11:0] ray_px,
  output logic [11:0] ray_py,
  output logic        hz_begin,
  output logic        vt_begin,
  input  logic        hz_end,
  input  logic        vt_end,
  input  logic        hz_found,
  input  logic        vt_found,
  input  logic [11:0] hz_wall_x,
  input  logic [11:0] hz_wall_y,
  input  logic [11:0] vt_wall_x,
  input  logic [11:0] vt_wall_y,
  output logic        col_valid,
  input  logic        col_ready,
  output logic [8:0]  col_index,
  output logic [12:0] col_dist,
  output logic        col_hit,
  output logic        col_is_vert
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SELECT, OUTPUT, DONE} state_t;
  state_t state, next;
  logic [12:0] acc, start_acc, step_acc, hz_dist, vt_dist;
  logic [16:0] start_sum;
  logic [8:0]  col;
  logic        hz_done, vt_done, hz_f, vt_f, hz_hit, vt_hit, hz_win, last, timeout;
  logic [11:0] hx, hy, vx, vy;

  function automatic logic [11:0] absdiff(input logic [11:0] a, input logic [11:0] b);
    return a > b ? a - b : b - a;
  endfunction

  // acc is the view angle in 1/16 degree, kept in 0..5759
  assign start_sum = {1'b0, player_angle, 4'b0} + 17'(HALF_FOV_Q4);
  assign start_acc = 13'(start_sum >= 17'd5760 ? start_sum - 17'd5760 : start_sum);
  assign step_acc  = acc < 13'(ANGLE_STEP_Q4) ? acc + 13'(5760 - ANGLE_STEP_Q4) : acc - 13'(ANGLE_STEP_Q4);
  assign hz_dist   = {1'b0, absdiff(hx, ray_px)} + {1'b0, absdiff(hy, ray_py)};
  assign vt_dist   = {1'b0, absdiff(vx, ray_px)} + {1'b0, absdiff(vy, ray_py)};
  assign hz_hit    = hz_done & hz_f;
  assign vt_hit    = vt_done & vt_f;
  assign hz_win    = hz_hit & (!vt_hit | hz_dist <= vt_dist);
  assign last      = col == 9'(NUM_COLS - 1);
  assign ray_alpha = {3'b0, acc[12:4]};
  assign frame_busy = state != IDLE;
  assign frame_done = state == DONE;
  assign hz_begin   = state == ISSUE;
  assign vt_begin   = state == ISSUE;
  assign col_valid  = state == OUTPUT;

`ifdef RAYSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  always_ff @(posedge clock)
    wait_cnt <= (!resetn || state != WAIT) ? '0 : wait_cnt + 1'b1;
  assign timeout = wait_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0 && TIMEOUT_CYCLES > 0;
`endif

  always_ff @(posedge clock)
    state <= !resetn ? IDLE : next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = frame_start ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = ((hz_done | hz_end) & (vt_done | vt_end)) | timeout ? SELECT : WAIT;
      SELECT:  next = OUTPUT;
      OUTPUT:  next = !col_ready ? OUTPUT : last ? DONE : ISSUE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      {ray_px, ray_py, acc, col} <= '0;
      {hz_done, vt_done, hz_f, vt_f, hx, hy, vx, vy} <= '0;
      {col_index, col_dist, col_hit, col_is_vert} <= '0;
    end else begin
      if (state == IDLE && frame_start) begin
        ray_px <= player_x;
        ray_py <= player_y;
        acc    <= start_acc;
        col    <= '0;
      end
      if (state == ISSUE) {hz_done, vt_done} <= '0;
      if (state == WAIT && hz_end) {hz_done, hz_f, hx, hy} <= {1'b1, hz_found, hz_wall_x, hz_wall_y};
      if (state == WAIT && vt_end) {vt_done, vt_f, vx, vy} <= {1'b1, vt_found, vt_wall_x, vt_wall_y};
      if (state == SELECT) begin
        col_index   <= col;
        col_hit     <= hz_hit | vt_hit;
        col_dist    <= hz_win ? hz_dist : vt_hit ? vt_dist : 13'h1fff;
        col_is_vert <= !hz_win & vt_hit;
      end
      if (state == OUTPUT && col_ready && !last) begin
        col <= col + 1'b1;
        acc <= step_acc;
      end
    end
  end
endmodule

// File: tb/tb_raycast_column_scheduler.sv
// tb_raycast_column_scheduler: directed checks of column scheduling, merge, hold, reset abort and angle wrap.
module tb_raycast_column_scheduler;
  logic        clock = 0, resetn = 0, frame_start = 0, col_ready = 0;
  logic [11:0] player_x = 0, player_y = 0, player_angle = 0;
  logic        hz_end = 0, vt_end = 0, hz_found = 0, vt_found = 0;
  logic [11:0] hz_wall_x = 0, hz_wall_y = 0, vt_wall_x = 0, vt_wall_y = 0;
  logic        frame_busy, frame_done, hz_begin, vt_begin, col_valid, col_hit, col_is_vert;
  logic [11:0] ray_alpha, ray_px, ray_py;
  logic [8:0]  col_index;
  logic [12:0] col_dist;
  logic        b_start = 0;
  logic [11:0] b_angle = 0;
  logic        b_busy, b_done, b_hzb, b_vtb, b_valid, b_hit, b_vert;
  logic [11:0] b_alpha, b_px, b_py;
  logic [8:0]  b_idx;
  logic [12:0] b_dist;
  int errors = 0, checks = 0;
  logic seen;

  always #5 clock = ~clock;

  raycast_column_scheduler #(.NUM_COLS(4), .HALF_FOV_Q4(480), .ANGLE_STEP_Q4(3), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start),
    .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
    .frame_busy(frame_busy), .frame_done(frame_done), .ray_alpha(ray_alpha),
    .ray_px(ray_px), .ray_py(ray_py), .hz_begin(hz_begin), .vt_begin(vt_begin),
    .hz_end(hz_end), .vt_end(vt_end), .hz_found(hz_found), .vt_found(vt_found),
    .hz_wall_x(hz_wall_x), .hz_wall_y(hz_wall_y), .vt_wall_x(vt_wall_x), .vt_wall_y(vt_wall_y),
    .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index), .col_dist(col_dist),
    .col_hit(col_hit), .col_is_vert(col_is_vert));

  // Engines answer every cycle and the sink is always ready, so only the angle sequence matters here
  raycast_column_scheduler #(.NUM_COLS(2), .HALF_FOV_Q4(0), .ANGLE_STEP_Q4(16), .TIMEOUT_CYCLES(8)) dut_wrap (
    .clock(clock), .resetn(resetn), .frame_start(b_start),
    .player_x(12'd0), .player_y(12'd0), .player_angle(b_angle),
    .frame_busy(b_busy), .frame_done(b_done), .ray_alpha(b_alpha),
    .ray_px(b_px), .ray_py(b_py), .hz_begin(b_hzb), .vt_begin(b_vtb),
    .hz_end(1'b1), .vt_end(1'b1), .hz_found(1'b0), .vt_found(1'b0),
    .hz_wall_x(12'd0), .hz_wall_y(12'd0), .vt_wall_x(12'd0), .vt_wall_y(12'd0),
    .col_valid(b_valid), .col_ready(1'b1), .col_index(b_idx), .col_dist(b_dist),
    .col_hit(b_hit), .col_is_vert(b_vert));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: both ends together, 1: hz then vt, 2: hz only (watchdog)
  task automatic col(input int mode, input logic hf, input logic [11:0] hx, input logic [11:0] hy,
                     input logic vf, input logic [11:0] vx, input logic [11:0] vy,
                     input int e_alpha, input int e_idx, input int e_dist, input int e_hit,
                     input int e_vert, input int hold);
    int lat;
    for (int i = 0; i < 20 && !hz_begin; i++) step();
    chk("hz_begin", 32'(hz_begin), 1);
    chk("vt_begin", 32'(vt_begin), 1);
    chk("alpha", 32'(ray_alpha), e_alpha);
    step();
    lat = 1;
    chk("begin_one_cycle", 32'(hz_begin), 0);
    {hz_found, hz_wall_x, hz_wall_y, vt_found, vt_wall_x, vt_wall_y} = {hf, hx, hy, vf, vx, vy};
    hz_end = 1;
    vt_end = mode == 0;
    step();
    lat++;
    hz_end = 0;
    vt_end = 0;
    if (mode == 1) begin
      chk("alpha_held", 32'(ray_alpha), e_alpha);
      vt_end = 1;
      step();
      lat++;
      vt_end = 0;
    end
    {hz_found, hz_wall_x, hz_wall_y, vt_found, vt_wall_x, vt_wall_y} = {~hf, 12'd4000, 12'd4000, ~vf, 12'd4000, 12'd4000};
    for (int i = 0; i < 30 && !col_valid; i++) begin
      step();
      lat++;
    end
    chk("col_valid", 32'(col_valid), 1);
    if (mode == 0) chk("latency", lat, 3);
    chk("col_index", 32'(col_index), e_idx);
    chk("col_dist", 32'(col_dist), e_dist);
    chk("col_hit", 32'(col_hit), e_hit);
    chk("col_is_vert", 32'(col_is_vert), e_vert);
    if (hold > 0) begin
      repeat (hold) step();
      chk("held_valid", 32'(col_valid), 1);
      chk("held_dist", 32'(col_dist), e_dist);
      chk("held_hit", 32'(col_hit), e_hit);
    end
    col_ready = 1;
    step();
    col_ready = 0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_busy", 32'(frame_busy), 0);
    chk("rst_valid", 32'(col_valid), 0);
    chk("rst_dist", 32'(col_dist), 0);
    chk("rst_alpha", 32'(ray_alpha), 0);
    chk("rst_begin", 32'(hz_begin), 0);
    resetn = 1;
    step();

    {player_x, player_y, player_angle} = {12'd100, 12'd100, 12'd0};
    frame_start = 1;
    step();
    frame_start = 0;
    chk("busy", 32'(frame_busy), 1);
    chk("ray_px", 32'(ray_px), 100);
    col(0, 1, 100, 50, 1, 130, 100, 30, 0, 30, 1, 1, 0);
    frame_start = 1;
    player_angle = 200;
    col(1, 1, 100, 50, 1, 150, 100, 29, 1, 50, 1, 0, 0);
    frame_start = 0;
    player_angle = 0;
    col(0, 0, 100, 50, 0, 130, 100, 29, 2, 8191, 0, 0, 10);
    col(0, 0, 100, 101, 1, 100, 120, 29, 3, 20, 1, 1, 0);
    chk("frame_done", 32'(frame_done), 1);
    step();
    chk("frame_done_pulse", 32'(frame_done), 0);
    chk("idle_busy", 32'(frame_busy), 0);

    {player_x, player_y, player_angle} = {12'd5, 12'd5, 12'd90};
    frame_start = 1;
    step();
    frame_start = 0;
    col(0, 1, 5, 9, 1, 8, 5, 120, 0, 3, 1, 1, 0);
    col(0, 1, 5, 5, 0, 0, 0, 119, 1, 0, 1, 0, 0);
    for (int i = 0; i < 20 && !hz_begin; i++) step();
    step();
    resetn = 0;
    step();
    chk("abort_busy", 32'(frame_busy), 0);
    chk("abort_valid", 32'(col_valid), 0);
    chk("abort_dist", 32'(col_dist), 0);
    chk("abort_alpha", 32'(ray_alpha), 0);
    chk("abort_px", 32'(ray_px), 0);
    chk("abort_idx", 32'(col_index), 0);
    chk("abort_hit", 32'(col_hit), 0);
    resetn = 1;
    seen = 0;
    repeat (5) begin
      step();
      seen = seen | frame_done;
    end
    chk("abort_no_done", 32'(seen), 0);
    frame_start = 1;
    step();
    frame_start = 0;
    col(0, 1, 5, 10, 0, 0, 0, 120, 0, 5, 1, 0, 0);
    for (int c = 1; c < 4; c++) col(0, 1, 5, 7, 0, 0, 0, 119, c, 2, 1, 0, 0);
    chk("restart_done", 32'(frame_done), 1);
    step();

`ifdef RAYSCHED_TIMEOUT_EN
    {player_x, player_y, player_angle} = {12'd100, 12'd100, 12'd0};
    frame_start = 1;
    step();
    frame_start = 0;
    col(2, 1, 100, 60, 0, 0, 0, 30, 0, 40, 1, 0, 0);
    resetn = 0;
    step();
    resetn = 1;
    step();
`endif

    b_angle = 12'd359;
    b_start = 1;
    step();
    b_start = 0;
    for (int i = 0; i < 20 && !b_hzb; i++) step();
    chk("wrap_a0", 32'(b_alpha), 359);
    step();
    for (int i = 0; i < 20 && !b_hzb; i++) step();
    chk("wrap_a1", 32'(b_alpha), 358);
    for (int i = 0; i < 20 && !b_done; i++) step();
    chk("wrap_done1", 32'(b_done), 1);
    step();
    b_angle = 12'd0;
    b_start = 1;
    step();
    b_start = 0;
    for (int i = 0; i < 20 && !b_hzb; i++) step();
    chk("wrap_b0", 32'(b_alpha), 0);
    step();
    for (int i = 0; i < 20 && !b_hzb; i++) step();
    chk("wrap_b1", 32'(b_alpha), 359);
    for (int i = 0; i < 20 && !b_done; i++) step();
    chk("wrap_done2", 32'(b_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
